// File: rtl/hazard_tracker_pkg.sv
// Shared pipeline constants: stage codes, descriptor layout, MD latencies,
// forward codes and the per-stage hazard entry type.
package hazard_tracker_pkg;

    typedef enum logic [4:0] {
        StageD = 5'd0,
        StageE = 5'd1,
        StageM = 5'd2,
        StageR = 5'd3,
        StageW = 5'd4
    } stage_e;

    // A tuse at or beyond W means the operand is not read at all
    localparam logic [4:0] TuseNone = StageW;

    // Descriptor layout {rs, rt, tuse1, tuse2, grf1, grf2, grfchange, tnew, wd3}
    localparam int unsigned HazardW      = 45;
    localparam int unsigned FieldW       = 5;
    localparam int unsigned RsOff        = 40;
    localparam int unsigned RtOff        = 35;
    localparam int unsigned Tuse1Off     = 30;
    localparam int unsigned Tuse2Off     = 25;
    localparam int unsigned Grf1Off      = 20;
    localparam int unsigned Grf2Off      = 15;
    localparam int unsigned GrfChangeOff = 10;
    localparam int unsigned TnewOff      = 5;
    localparam int unsigned Wd3Off       = 0;

    localparam logic [3:0] MdLatMult = 4'd5;
    localparam logic [3:0] MdLatDiv  = 4'd10;

    localparam logic [1:0] FwdGrf = 2'b00;
    localparam logic [1:0] FwdE   = 2'b01;
    localparam logic [1:0] FwdM   = 2'b10;
    localparam logic [1:0] FwdW   = 2'b11;

    typedef struct packed {
        logic [4:0] grf1;
        logic [4:0] grf2;
        logic [4:0] dest;
        logic [1:0] avail;
        logic       start;
        logic       div;
    } stage_t;

    function automatic logic [4:0] get_field(input logic [HazardW-1:0] desc,
                                             input int unsigned off);
        return desc[off +: FieldW];
    endfunction

endpackage

// File: rtl/hazard_tracker_if.sv
// Decoder <-> hazard tracker signal bundle.
interface hazard_tracker_if;

    logic [hazard_tracker_pkg::HazardW-1:0] d_hazard;
    logic       d_md;
    logic       d_start;
    logic       d_div;
    logic       flush;
    logic       stall;
    logic [1:0] fwd_d1;
    logic [1:0] fwd_d2;
    logic [1:0] fwd_e1;
    logic [1:0] fwd_e2;
    logic       fwd_m2;
    logic       md_busy;

    modport master (
        output d_hazard, d_md, d_start, d_div, flush,
        input  stall, fwd_d1, fwd_d2, fwd_e1, fwd_e2, fwd_m2, md_busy
    );

    modport slave (
        input  d_hazard, d_md, d_start, d_div, flush,
        output stall, fwd_d1, fwd_d2, fwd_e1, fwd_e2, fwd_m2, md_busy
    );

endinterface

// File: rtl/hz_stage_reg.sv
// One pipeline hazard entry (E, M or W); loads a bubble when told to.
module hz_stage_reg
    import hazard_tracker_pkg::*;
(
    input  logic   clk,
    input  logic   rst_n,
    input  logic   bubble,
    input  stage_t d,
    output stage_t q
);

    // Entry register, cleared asynchronously by reset
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            q <= '0;
        end else if (bubble) begin
            q <= '0;
        end else begin
            q <= d;
        end
    end

endmodule

// File: rtl/hazard_tracker.sv
// Stall / forward decision logic over the E, M, W producer entries plus the
// multiply/divide busy counter.
module hazard_tracker
    import hazard_tracker_pkg::*;
(
    input  logic           clk,
    input  logic           rst_n,
    hazard_tracker_if.slave hz
);

    localparam logic [1:0] LagE = 2'(StageE);
    localparam logic [1:0] LagM = 2'(StageM);

    stage_t     d_entry;
    stage_t     e_q;
    stage_t     m_q;
    stage_t     w_q;
    logic [4:0] tuse1;
    logic [4:0] tuse2;
    logic [4:0] tnew;
    logic [1:0] rem_e;
    logic [1:0] rem_m;
    logic       stall_dat;
    logic       stall_md;
    logic [3:0] md_cnt_q;
    logic [3:0] md_cnt_d;
    logic       unused_fields;

    // Operand k stalls if a producer still needs more cycles than the reader can wait
    function automatic logic op_stall(input logic [4:0] r, input logic [4:0] tuse,
                                      input stage_t e, input stage_t m,
                                      input logic [1:0] re, input logic [1:0] rm);
        if (tuse >= TuseNone || r == 5'd0) return 1'b0;
        return (e.dest == r && {3'b000, re} > tuse) || (m.dest == r && {3'b000, rm} > tuse);
    endfunction

    // Youngest eligible producer wins; E is only a candidate for D-stage readers
    function automatic logic [1:0] fwd_pick(input logic [4:0] r, input logic e_ok,
                                            input stage_t e, input stage_t m, input stage_t w);
        if (r == 5'd0) return FwdGrf;
        if (e_ok && e.dest == r && e.avail <= LagE) return FwdE;
        if (m.dest == r && m.avail <= LagM) return FwdM;
        if (w.dest == r) return FwdW;
        return FwdGrf;
    endfunction

    // Unpack the D descriptor into entry format; avail saturates at 3
    always_comb begin
        tuse1         = get_field(hz.d_hazard, Tuse1Off);
        tuse2         = get_field(hz.d_hazard, Tuse2Off);
        tnew          = get_field(hz.d_hazard, TnewOff);
        d_entry       = '0;
        d_entry.grf1  = get_field(hz.d_hazard, Grf1Off);
        d_entry.grf2  = get_field(hz.d_hazard, Grf2Off);
        d_entry.dest  = get_field(hz.d_hazard, GrfChangeOff);
        d_entry.avail = (tnew > 5'd3) ? 2'd3 : tnew[1:0];
        d_entry.start = hz.d_start;
        d_entry.div   = hz.d_div;
    end

    assign unused_fields = ^{get_field(hz.d_hazard, RsOff), get_field(hz.d_hazard, RtOff),
                             get_field(hz.d_hazard, Wd3Off)};

    hz_stage_reg u_e_reg (
        .clk    (clk),
        .rst_n  (rst_n),
        .bubble (hz.flush | hz.stall),
        .d      (d_entry),
        .q      (e_q)
    );

    hz_stage_reg u_m_reg (
        .clk    (clk),
        .rst_n  (rst_n),
        .bubble (hz.flush),
        .d      (e_q),
        .q      (m_q)
    );

    hz_stage_reg u_w_reg (
        .clk    (clk),
        .rst_n  (rst_n),
        .bubble (hz.flush),
        .d      (m_q),
        .q      (w_q)
    );

    // Stall and forward-select decisions from current entries and D inputs
    always_comb begin
        rem_e     = (e_q.avail > LagE) ? e_q.avail - LagE : 2'd0;
        rem_m     = (m_q.avail > LagM) ? m_q.avail - LagM : 2'd0;
        stall_dat = op_stall(d_entry.grf1, tuse1, e_q, m_q, rem_e, rem_m) |
                    op_stall(d_entry.grf2, tuse2, e_q, m_q, rem_e, rem_m);
        stall_md  = hz.d_md & (e_q.start | (md_cnt_q != 4'd0));
        hz.stall  = stall_dat | stall_md;
        hz.fwd_d1 = fwd_pick(d_entry.grf1, 1'b1, e_q, m_q, w_q);
        hz.fwd_d2 = fwd_pick(d_entry.grf2, 1'b1, e_q, m_q, w_q);
        hz.fwd_e1 = fwd_pick(e_q.grf1, 1'b0, e_q, m_q, w_q);
        hz.fwd_e2 = fwd_pick(e_q.grf2, 1'b0, e_q, m_q, w_q);
        hz.fwd_m2 = (m_q.grf2 != 5'd0) && (w_q.dest == m_q.grf2);
        hz.md_busy = (md_cnt_q != 4'd0);
    end

    // MD counter: load latency when an op leaves E, else count down to zero.
    // Flush does not cancel an op that already launched.
    always_comb begin
        md_cnt_d = md_cnt_q;
        if (e_q.start && !hz.flush) begin
            md_cnt_d = e_q.div ? MdLatDiv : MdLatMult;
        end else if (md_cnt_q != 4'd0) begin
            md_cnt_d = md_cnt_q - 4'd1;
        end
    end

    // MD counter register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            md_cnt_q <= 4'd0;
        end else begin
            md_cnt_q <= md_cnt_d;
        end
    end

endmodule
